// File: rtl/regfile_pkg.sv
// regfile_pkg: shared state encoding, default sizes and packed-slice helper for the register file.
package regfile_pkg;
    typedef enum logic {CLEAR, RUN} state_t;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 32;
    localparam int DEF_NUM_RD = 2;
    function automatic int slice_lo(input int k, input int w);
        return k * w;
    endfunction
endpackage

// File: rtl/regfile_if.sv
// regfile_if: clear control, write port and packed read ports of the register file.
interface regfile_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int NUM_RD = DEF_NUM_RD
);
    localparam int AW = $clog2(DEPTH);
    logic                     clr_req;
    logic                     busy;
    logic                     wr_en;
    logic [AW-1:0]            wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic [NUM_RD*AW-1:0]     rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    modport master (output clr_req, wr_en, wr_addr, wr_data, rd_addr, input busy, rd_data);
    modport slave  (input clr_req, wr_en, wr_addr, wr_data, rd_addr, output busy, rd_data);
endinterface

// File: rtl/regfile_clear_ctrl.sv
// regfile_clear_ctrl: sweeps every entry to zero, one per cycle, after reset or on request.
module regfile_clear_ctrl
    import regfile_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_req,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);
    state_t        state, state_nx;
    logic [AW-1:0] ptr, ptr_nx;
    logic          last;
    assign last = ptr == AW'(DEPTH - 1);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
        end
    end
    // a request arriving mid-sweep is dropped rather than restarting the sweep
    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        busy     = state == CLEAR;
        clr_we   = state == CLEAR;
        clr_addr = ptr;
        if (state == CLEAR) begin
            state_nx = last ? RUN : CLEAR;
            ptr_nx   = last ? '0 : ptr + AW'(1);
        end else if (clr_req) begin
            state_nx = CLEAR;
            ptr_nx   = '0;
        end
    end
endmodule

// File: rtl/regfile_param.sv
// regfile_param: parametrised register file with hardware clear sweep and optional zero register.
// Define REGFILE_BYPASS_EN for write-first forwarding of same-cycle writes to the read ports.
module regfile_param
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int ZERO_REG = 1
) (
    input  logic     clk,
    input  logic     reset,
    regfile_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    logic              clr_we;
    logic [AW-1:0]     clr_addr;
    logic              usr_we;
    logic [DATA_W-1:0] mem [DEPTH];
    function automatic logic ok(input logic [AW-1:0] a);
        return (32'(a) < DEPTH) && !(ZERO_REG != 0 && a == '0);
    endfunction
    regfile_clear_ctrl #(.DEPTH(DEPTH)) u_clr (
        .clk     (clk),
        .reset   (reset),
        .clr_req (bus.clr_req),
        .busy    (bus.busy),
        .clr_we  (clr_we),
        .clr_addr(clr_addr)
    );
    assign usr_we = bus.wr_en && !bus.busy && ok(bus.wr_addr);
    always_ff @(posedge clk) begin
        if (clr_we)
            mem[clr_addr] <= '0;
        else if (usr_we)
            mem[bus.wr_addr] <= bus.wr_data;
    end
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0] a;
        logic          hit;
        assign a = bus.rd_addr[slice_lo(k, AW) +: AW];
`ifdef REGFILE_BYPASS_EN
        assign hit = usr_we && a == bus.wr_addr;
`else
        assign hit = 1'b0;
`endif
        assign bus.rd_data[slice_lo(k, DATA_W) +: DATA_W] =
            (bus.busy || !ok(a)) ? '0 : hit ? bus.wr_data : mem[a];
    end
endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: directed scoreboard bench over three configurations of regfile_param.
module tb_regfile_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
`ifdef REGFILE_BYPASS_EN
    localparam logic [31:0] RDW_EXP = 32'hA5A5A5A5;
`else
    localparam logic [31:0] RDW_EXP = 32'h00000011;
`endif
    regfile_if #(.DATA_W(32), .DEPTH(32), .NUM_RD(2)) a_if ();
    regfile_if #(.DATA_W(32), .DEPTH(32), .NUM_RD(2)) b_if ();
    regfile_if #(.DATA_W(32), .DEPTH(20), .NUM_RD(3)) c_if ();
    regfile_param #(.DATA_W(32), .DEPTH(32), .NUM_RD(2), .ZERO_REG(1)) dut_a (.clk(clk), .reset(rst_a), .bus(a_if));
    regfile_param #(.DATA_W(32), .DEPTH(32), .NUM_RD(2), .ZERO_REG(0)) dut_b (.clk(clk), .reset(rst_b), .bus(b_if));
    regfile_param #(.DATA_W(32), .DEPTH(20), .NUM_RD(3), .ZERO_REG(1)) dut_c (.clk(clk), .reset(rst_c), .bus(c_if));

    string       q_name[$];
    int          q_dut[$];
    int          q_port[$];
    logic [31:0] q_exp[$];
    int          compared = 0;
    int          mismatched = 0;

    task automatic expect_v(input string n, input int d, input int p, input logic [31:0] e);
        q_name.push_back(n);
        q_dut.push_back(d);
        q_port.push_back(p);
        q_exp.push_back(e);
    endtask

    function automatic logic [31:0] actual(input int d, input int p);
        if (p < 0)
            return d == 0 ? 32'(a_if.busy) : d == 1 ? 32'(b_if.busy) : 32'(c_if.busy);
        case (d)
            0:       return a_if.rd_data[p*32 +: 32];
            1:       return b_if.rd_data[p*32 +: 32];
            default: return c_if.rd_data[p*32 +: 32];
        endcase
    endfunction

    always @(negedge clk) begin : monitor
        string       n;
        int          d, p;
        logic [31:0] e, act;
        while (q_exp.size() > 0) begin
            n = q_name.pop_front();
            d = q_dut.pop_front();
            p = q_port.pop_front();
            e = q_exp.pop_front();
            act = actual(d, p);
            compared++;
            if (act !== e) begin
                mismatched++;
                $display("FAIL %s: got %h, wanted %h", n, act, e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        a_if.clr_req = 0; a_if.wr_en = 0; a_if.wr_addr = '0; a_if.wr_data = '0; a_if.rd_addr = '0;
        b_if.clr_req = 0; b_if.wr_en = 0; b_if.wr_addr = '0; b_if.wr_data = '0; b_if.rd_addr = '0;
        c_if.clr_req = 0; c_if.wr_en = 0; c_if.wr_addr = '0; c_if.wr_data = '0; c_if.rd_addr = '0;
        repeat (3) begin
            step();
            expect_v("rst_busy", 0, -1, 1);
            expect_v("rst_rd", 0, 1, 0);
        end
        rst_a = 0; rst_b = 0; rst_c = 0;
        expect_v("sweep_busy0", 0, -1, 1);
        for (int k = 1; k <= 32; k++) begin
            step();
            expect_v("sweep_busy_a", 0, -1, 32'(k < 32));
            if (k <= 20) expect_v("sweep_busy_c", 2, -1, 32'(k < 20));
        end
        for (int i = 0; i < 32; i++) begin
            step();
            a_if.rd_addr = {5'(31 - i), 5'(i)};
            b_if.rd_addr = {5'(31 - i), 5'(i)};
            expect_v("cleared_p0", 0, 0, 0);
            expect_v("cleared_p1", 0, 1, 0);
            expect_v("cleared_b", 1, 0, 0);
        end
        step();
        a_if.wr_en = 1; a_if.wr_addr = 5; a_if.wr_data = 32'hDEADBEEF;
        step();
        a_if.wr_addr = 31; a_if.wr_data = 32'h00001234;
        step();
        a_if.wr_en = 0; a_if.rd_addr = {5'd31, 5'd5};
        expect_v("rd_r5", 0, 0, 32'hDEADBEEF);
        expect_v("rd_r31", 0, 1, 32'h00001234);
        step();
        a_if.wr_en = 1; a_if.wr_addr = 0; a_if.wr_data = 32'hFFFFFFFF;
        b_if.wr_en = 1; b_if.wr_addr = 0; b_if.wr_data = 32'hFFFFFFFF;
        step();
        a_if.wr_en = 0; a_if.rd_addr = '0;
        b_if.wr_en = 0; b_if.rd_addr = '0;
        expect_v("zero_p0", 0, 0, 0);
        expect_v("zero_p1", 0, 1, 0);
        expect_v("nozero_p0", 1, 0, 32'hFFFFFFFF);
        expect_v("nozero_p1", 1, 1, 32'hFFFFFFFF);
        step();
        a_if.wr_en = 1; a_if.wr_addr = 7; a_if.wr_data = 32'h00000011;
        step();
        a_if.wr_data = 32'hA5A5A5A5; a_if.rd_addr = {5'd0, 5'd7};
        expect_v("rdw_same", 0, 0, RDW_EXP);
        step();
        a_if.wr_en = 0;
        expect_v("rdw_next", 0, 0, 32'hA5A5A5A5);
        step();
        a_if.wr_en = 1; a_if.wr_addr = 3; a_if.wr_data = 32'h00000055;
        step();
        a_if.wr_en = 0; a_if.rd_addr = {5'd4, 5'd3}; a_if.clr_req = 1;
        expect_v("r3_pre", 0, 0, 32'h00000055);
        for (int k = 0; k <= 32; k++) begin
            step();
            a_if.clr_req = (k == 10);
            a_if.wr_en = (k == 20); a_if.wr_addr = 4; a_if.wr_data = 32'h00000099;
            expect_v("clr_busy", 0, -1, 32'(k < 32));
            if (k == 1) expect_v("rd_busy", 0, 0, 0);
        end
        expect_v("r3_cleared", 0, 0, 0);
        expect_v("r4_dropped", 0, 1, 0);
        step();
        c_if.wr_en = 1; c_if.wr_addr = 19; c_if.wr_data = 32'h0000BEEF;
        step();
        c_if.wr_addr = 25; c_if.wr_data = 32'h0000CAFE;
        step();
        c_if.wr_en = 0; c_if.rd_addr = {5'd25, 5'd19, 5'd25};
        expect_v("c_oob_p0", 2, 0, 0);
        expect_v("c_r19", 2, 1, 32'h0000BEEF);
        expect_v("c_oob_p2", 2, 2, 0);
        step();
        rst_c = 1;
        step();
        rst_c = 0;
        for (int k = 1; k <= 8; k++) begin
            step();
            expect_v("c_sweep", 2, -1, 1);
        end
        rst_c = 1;
        expect_v("c_rst_mid", 2, -1, 1);
        step();
        step();
        rst_c = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            expect_v("c_restart_busy", 2, -1, 32'(k < 20));
        end
        expect_v("c_r19_cleared", 2, 1, 0);
        step();
        step();
        if (q_exp.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending, wanted 0", q_exp.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
